// File: rtl/ray_core_scheduler.sv
// ray_core_scheduler
// Launches NUM_CORES ray-generator cores for one frame and merges their
// interleaved ray streams into a single stream in strict pixel order.
// Core k produces pixels k, k+NUM_CORES, k+2*NUM_CORES, ..., so the cores
// are drained round-robin. Every pixel index is checked against the expected
// sequence, the frame is counted to completion and a done pulse is emitted.
//
// Ports:
//   clk, reset_n           clock; asynchronous reset (active-high)
//   start, abort           frame start (IDLE only) / synchronous cancel
//   image_width/height     frame dimensions, latched as a product at start
//   core_en, core_op_code  one-cycle launch pulse / constant NUM_CORES-1
//   core_valid/ready       per-core ray handshake
//   core_dir_x/y/z         flattened per-core ray directions
//   core_index             flattened per-core pixel index
//   out_valid/ready        merged ray handshake
//   out_dir_x/y/z          merged ray direction
//   out_index              pixel index of the merged ray
//   busy                   high while a frame is in flight
//   frame_done             one-cycle pulse at the end of a frame
//   seq_error              sticky index mismatch, cleared by the next start
module ray_core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int DIR_W     = 32,
  parameter int IDX_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [12:0]                image_width,
  input  logic [12:0]                image_height,
  output logic                       core_en,
  output logic [2:0]                 core_op_code,
  input  logic [NUM_CORES-1:0]       core_valid,
  output logic [NUM_CORES-1:0]       core_ready,
  input  logic [NUM_CORES*DIR_W-1:0] core_dir_x,
  input  logic [NUM_CORES*DIR_W-1:0] core_dir_y,
  input  logic [NUM_CORES*DIR_W-1:0] core_dir_z,
  input  logic [NUM_CORES*IDX_W-1:0] core_index,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIR_W-1:0]           out_dir_x,
  output logic [DIR_W-1:0]           out_dir_y,
  output logic [DIR_W-1:0]           out_dir_z,
  output logic [IDX_W-1:0]           out_index,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       seq_error
);

  localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, MERGE, FLUSH, DONE} state_t;

  state_t            state;
  logic [SEL_W-1:0]  sel;
  logic [25:0]       expected;
  logic [25:0]       total;
  logic [25:0]       frame_total;

  logic              sel_valid;
  logic [DIR_W-1:0]  sel_dir_x;
  logic [DIR_W-1:0]  sel_dir_y;
  logic [DIR_W-1:0]  sel_dir_z;
  logic [IDX_W-1:0]  sel_index;
  logic              take_ok;
  logic              accept;
  logic              index_ok;
  logic              last_ray;

  assign frame_total  = 26'(image_width) * 26'(image_height);
  assign core_op_code = 3'(NUM_CORES - 1);
  assign busy         = (state != IDLE);

  // Select the currently scheduled core's ray. Only one core is ever
  // looked at, which is what keeps the merged stream in pixel order.
  always_comb begin
    sel_valid = 1'b0;
    sel_dir_x = '0;
    sel_dir_y = '0;
    sel_dir_z = '0;
    sel_index = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_valid = core_valid[k];
        sel_dir_x = core_dir_x[k*DIR_W +: DIR_W];
        sel_dir_y = core_dir_y[k*DIR_W +: DIR_W];
        sel_dir_z = core_dir_z[k*DIR_W +: DIR_W];
        sel_index = core_index[k*IDX_W +: IDX_W];
      end
    end
  end

  // The output register can take a new ray when it is empty or being
  // drained this cycle, giving full throughput without a skid buffer.
  assign take_ok = !out_valid || out_ready;

  always_comb begin
    core_ready = '0;
    if (state == MERGE) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (sel == SEL_W'(k)) core_ready[k] = take_ok;
      end
    end
  end

  // abort wins over a simultaneous accept, so nothing is loaded that cycle.
  assign accept   = (state == MERGE) && sel_valid && take_ok && !abort;
  assign index_ok = (sel_index == IDX_W'(expected));
  assign last_ray = (expected == total - 26'd1);

  // Frame sequencer plus the merged-ray output register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      expected   <= '0;
      total      <= '0;
      core_en    <= 1'b0;
      frame_done <= 1'b0;
      seq_error  <= 1'b0;
      out_valid  <= 1'b0;
      out_dir_x  <= '0;
      out_dir_y  <= '0;
      out_dir_z  <= '0;
      out_index  <= '0;
    end else begin
      core_en    <= 1'b0;
      frame_done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          out_valid <= 1'b1;
          out_dir_x <= sel_dir_x;
          out_dir_y <= sel_dir_y;
          out_dir_z <= sel_dir_z;
          // The forwarded index is always the expected one, even when
          // the core reported something else.
          out_index <= IDX_W'(expected);
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (start) begin
              if (frame_total == 26'd0) begin
                frame_done <= 1'b1;
              end else begin
                total     <= frame_total;
                seq_error <= 1'b0;
                expected  <= '0;
                sel       <= '0;
                core_en   <= 1'b1;
                state     <= LAUNCH;
              end
            end
          end
          LAUNCH: state <= MERGE;
          MERGE: begin
            if (accept) begin
              if (!index_ok) seq_error <= 1'b1;
              expected <= expected + 26'd1;
              sel      <= (sel == LAST_SEL) ? '0 : sel + 1'b1;
              if (last_ray) state <= FLUSH;
            end
          end
          FLUSH: begin
            if (!out_valid || out_ready) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ray_core_scheduler.sv
// tb_ray_core_scheduler
// Directed bench for ray_core_scheduler with NUM_CORES=4. A small core model
// hands out pixels k, k+4, ... per core, with optional per-pixel stall and
// index corruption. A negedge monitor records every merged ray taken
// downstream and every core accept; the main sequence checks them.
module tb_ray_core_scheduler;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int IW = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [12:0]       image_width;
  logic [12:0]       image_height;
  logic              core_en;
  logic [2:0]        core_op_code;
  logic [NC-1:0]     core_valid;
  logic [NC-1:0]     core_ready;
  logic [NC*DW-1:0]  core_dir_x;
  logic [NC*DW-1:0]  core_dir_y;
  logic [NC*DW-1:0]  core_dir_z;
  logic [NC*IW-1:0]  core_index;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_dir_x;
  logic [DW-1:0]     out_dir_y;
  logic [DW-1:0]     out_dir_z;
  logic [IW-1:0]     out_index;
  logic              busy;
  logic              frame_done;
  logic              seq_error;

  ray_core_scheduler #(.NUM_CORES(NC), .DIR_W(DW), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .image_width  (image_width),
    .image_height (image_height),
    .core_en      (core_en),
    .core_op_code (core_op_code),
    .core_valid   (core_valid),
    .core_ready   (core_ready),
    .core_dir_x   (core_dir_x),
    .core_dir_y   (core_dir_y),
    .core_dir_z   (core_dir_z),
    .core_index   (core_index),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_dir_x    (out_dir_x),
    .out_dir_y    (out_dir_y),
    .out_dir_z    (out_dir_z),
    .out_index    (out_index),
    .busy         (busy),
    .frame_done   (frame_done),
    .seq_error    (seq_error)
  );

  always #5 clk = ~clk;

  // Core model state
  int unsigned cnt [NC];
  int unsigned pix [NC];
  int unsigned tot;
  logic        launched;
  int unsigned cyc = 0;
  int unsigned stall_pix = 32'hFFFF_FFFF;
  int unsigned stall_release = 0;
  int unsigned bad_pix = 32'hFFFF_FFFF;
  logic [IW-1:0] bad_val = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Each core rewinds on the launch pulse and advances on its own handshake.
  always @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      launched <= 1'b0;
      for (int k = 0; k < NC; k++) cnt[k] <= 0;
    end else if (core_en) begin
      launched <= 1'b1;
      for (int k = 0; k < NC; k++) cnt[k] <= 0;
    end else begin
      for (int k = 0; k < NC; k++)
        if (core_valid[k] && core_ready[k]) cnt[k] <= cnt[k] + 1;
    end
  end

  always_comb begin
    tot = 32'(image_width) * 32'(image_height);
    for (int k = 0; k < NC; k++) pix[k] = 32'(k) + cnt[k] * 32'(NC);
  end

  always_comb begin
    core_valid = '0;
    core_index = '0;
    core_dir_x = '0;
    core_dir_y = '0;
    core_dir_z = '0;
    for (int k = 0; k < NC; k++) begin
      core_valid[k] = launched && (pix[k] < tot) &&
                      !((pix[k] == stall_pix) && (cyc < stall_release));
      core_index[k*IW +: IW] = (pix[k] == bad_pix) ? bad_val : IW'(pix[k]);
      core_dir_x[k*DW +: DW] = DW'(32'h1000_0000 + pix[k]);
      core_dir_y[k*DW +: DW] = DW'(32'h2000_0000 + pix[k]);
      core_dir_z[k*DW +: DW] = DW'(32'h3000_0000 + pix[k]);
    end
  end

  // Monitor: records rays taken downstream, core accepts, pulses, and
  // counts stability / one-hot violations.
  logic [IW-1:0] got_idx [$];
  logic [DW-1:0] got_dx [$];
  logic [DW-1:0] got_dy [$];
  logic [DW-1:0] got_dz [$];
  int            got_cyc [$];
  int            acc_sel [$];
  int            ncyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            en_cnt = 0;
  int            busy_cnt = 0;
  int            viol = 0;
  logic          prev_ov = 1'b0;
  logic          prev_or = 1'b0;
  logic [IW-1:0] prev_idx = '0;
  logic [DW-1:0] prev_dx = '0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (out_valid && out_ready) begin
      got_idx.push_back(out_index);
      got_dx.push_back(out_dir_x);
      got_dy.push_back(out_dir_y);
      got_dz.push_back(out_dir_z);
      got_cyc.push_back(ncyc);
    end
    for (int k = 0; k < NC; k++)
      if (core_valid[k] && core_ready[k]) acc_sel.push_back(k);
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= ncyc;
    end
    if (core_en) en_cnt <= en_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if ((prev_ov && !prev_or &&
         (!out_valid || out_index != prev_idx || out_dir_x != prev_dx)) ||
        ($countones(core_ready) > 1))
      viol <= viol + 1;
    prev_ov  <= out_valid;
    prev_or  <= out_ready;
    prev_idx <= out_index;
    prev_dx  <= out_dir_x;
  end

  int cmp_total = 0;
  int cmp_bad = 0;

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    cmp_total++;
    assert (obs === exp) else begin
      cmp_bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a frame and waits (bounded) for frame_done, optionally toggling
  // out_ready every cycle. Called and returns at posedge+1.
  task automatic run_frame(input logic [12:0] w, input logic [12:0] h,
                           input bit toggle);
    int n;
    int d0;
    d0 = done_cnt;
    image_width  = w;
    image_height = h;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    check_output("frame_timeout", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
  endtask

  // Checks that the rays since index b are pixels 0..7 with matching dirs.
  task automatic check_rays(input string tag, input int b);
    check_output({tag, "_count"}, 64'(got_idx.size() - b), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("%s_idx%0d", tag, i), 64'(got_idx[b+i]), 64'(i));
      check_output($sformatf("%s_dx%0d", tag, i), 64'(got_dx[b+i]),
                   64'(32'h1000_0000 + i));
    end
  endtask

  int b_idx;
  int b_acc;
  int d0;
  int e0;
  int bz0;
  int n;

  initial begin
    reset_n      = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    out_ready    = 1'b1;
    image_width  = 13'd0;
    image_height = 13'd0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_core_en", 64'(core_en), 64'd0);
    check_output("rst_core_ready", 64'(core_ready), 64'd0);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_index", 64'(out_index), 64'd0);
    check_output("rst_frame_done", 64'(frame_done), 64'd0);
    check_output("rst_seq_error", 64'(seq_error), 64'd0);
    check_output("op_code", 64'(core_op_code), 64'd3);
    #3 reset_n = 1'b0;
    @(posedge clk); #1;

    $display("[TB] 4x2 frame, out_ready high");
    b_idx = got_idx.size(); b_acc = acc_sel.size(); d0 = done_cnt; e0 = en_cnt;
    run_frame(13'd4, 13'd2, 1'b0);
    check_rays("t1", b_idx);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("t1_sel%0d", i), 64'(acc_sel[b_acc+i]), 64'(i % 4));
    check_output("t1_dy6", 64'(got_dy[b_idx+6]), 64'h2000_0006);
    check_output("t1_dz6", 64'(got_dz[b_idx+6]), 64'h3000_0006);
    check_output("t1_span", 64'(got_cyc[b_idx+7] - got_cyc[b_idx]), 64'd7);
    check_output("t1_done_cyc", 64'(done_cyc), 64'(got_cyc[b_idx+7] + 1));
    check_output("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_output("t1_en_cnt", 64'(en_cnt - e0), 64'd1);
    check_output("t1_seq_error", 64'(seq_error), 64'd0);

    $display("[TB] 4x2 frame, out_ready toggling");
    b_idx = got_idx.size();
    run_frame(13'd4, 13'd2, 1'b1);
    check_rays("t2", b_idx);
    check_output("t2_stable", 64'(viol), 64'd0);

    $display("[TB] core 2 stalls on pixel 2");
    b_idx = got_idx.size(); b_acc = acc_sel.size();
    stall_pix = 2;
    stall_release = cyc + 9;
    run_frame(13'd4, 13'd2, 1'b0);
    stall_pix = 32'hFFFF_FFFF;
    check_rays("t3", b_idx);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("t3_sel%0d", i), 64'(acc_sel[b_acc+i]), 64'(i % 4));
    check_output("t3_span", 64'(got_cyc[b_idx+7] - got_cyc[b_idx]), 64'd12);

    $display("[TB] core 1 reports index 9 for pixel 5");
    b_idx = got_idx.size(); d0 = done_cnt;
    bad_pix = 5;
    bad_val = 32'd9;
    run_frame(13'd4, 13'd2, 1'b0);
    bad_pix = 32'hFFFF_FFFF;
    check_rays("t4", b_idx);
    check_output("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check_output("t4_seq_error_sticky", 64'(seq_error), 64'd1);
    run_frame(13'd4, 13'd2, 1'b0);
    check_output("t4_seq_error_cleared", 64'(seq_error), 64'd0);

    $display("[TB] zero-sized frame");
    d0 = done_cnt; e0 = en_cnt; bz0 = busy_cnt;
    image_width  = 13'd0;
    image_height = 13'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("t5_done_pulse", 64'(frame_done), 64'd1);
    check_output("t5_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_output("t5_done_low", 64'(frame_done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_output("t5_no_launch", 64'(en_cnt - e0), 64'd0);
    check_output("t5_never_busy", 64'(busy_cnt - bz0), 64'd0);

    $display("[TB] abort after three accepts");
    d0 = done_cnt; b_acc = acc_sel.size();
    image_width  = 13'd4;
    image_height = 13'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (acc_sel.size() - b_acc < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("t6_wait", 64'(n < 50), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_output("t6_busy", 64'(busy), 64'd0);
    check_output("t6_out_valid", 64'(out_valid), 64'd0);
    check_output("t6_core_ready", 64'(core_ready), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_output("t6_no_done", 64'(done_cnt - d0), 64'd0);
    check_output("t6_idle", 64'(busy), 64'd0);

    $display("[TB] reset mid-frame");
    b_acc = acc_sel.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (acc_sel.size() - b_acc < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("t7_wait", 64'(n < 50), 64'd1);
    check_output("t7_pre_busy", 64'(busy), 64'd1);
    reset_n = 1'b1;
    #1;
    check_output("t7_busy", 64'(busy), 64'd0);
    check_output("t7_out_valid", 64'(out_valid), 64'd0);
    check_output("t7_out_index", 64'(out_index), 64'd0);
    check_output("t7_out_dir_x", 64'(out_dir_x), 64'd0);
    check_output("t7_core_ready", 64'(core_ready), 64'd0);
    check_output("t7_core_en", 64'(core_en), 64'd0);
    #2 reset_n = 1'b0;
    @(posedge clk); #1;

    $display("[TB] full frame after reset");
    b_idx = got_idx.size(); e0 = en_cnt;
    run_frame(13'd4, 13'd2, 1'b0);
    check_rays("t8", b_idx);
    check_output("t8_en_cnt", 64'(en_cnt - e0), 64'd1);
    check_output("t8_seq_error", 64'(seq_error), 64'd0);
    check_output("t8_viol", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", cmp_total, cmp_bad);
    $finish;
  end

endmodule
